// File: rtl/test1_stim.sv
// Stimulus/response harness for the test1 timing sample: drives LFSR vectors on a_out and
// checks b_in against a golden model of the two-register-stage c4/c5 path.
module test1_stim #(
  parameter logic [6:0] SEED = 7'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] count,
  output logic [6:0] a_out,
  input  logic       b_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
);

  localparam logic [6:0] SEED_EFF = (SEED == 7'h00) ? 7'h01 : SEED;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FLUSH, S_DONE} state_t;

  state_t     state;
  logic [6:0] lfsr;
  logic [6:0] h1;
  logic [6:0] h2;
  logic [7:0] n;
  logic [8:0] k;

  function automatic logic c4(input logic [6:0] v);
    return ~(v[0] & v[1]) & ~v[2];
  endfunction

  function automatic logic c5(input logic [6:0] v);
    return v[3] | v[4] | (v[5] & v[6]);
  endfunction

  logic [6:0] lfsr_nxt;
  logic       mismatch;
  logic [7:0] err_nxt;

  // Cycles 0 and 1 are skipped: the netlist flops hold unknown pre-run values.
  always_comb begin
    lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    mismatch = busy && (k >= 9'd2) && (b_in != (c4(h2) & c5(h1)));
    err_nxt  = (mismatch && (err_count != 8'hff)) ? err_count + 8'd1 : err_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= SEED_EFF;
      h1        <= '0;
      h2        <= '0;
      n         <= '0;
      k         <= '0;
      a_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      if (busy) begin
        h1        <= a_out;
        h2        <= h1;
        err_count <= err_nxt;
        k         <= k + 9'd1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count <= '0;
            if (count == 8'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_DRIVE;
              n     <= count;
              lfsr  <= SEED_EFF;
              a_out <= SEED_EFF;
              busy  <= 1'b1;
              k     <= '0;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        S_DRIVE: begin
          if (k == ({1'b0, n} - 9'd1)) begin
            state <= S_FLUSH;
            a_out <= '0;
          end else begin
            a_out <= lfsr_nxt;
            lfsr  <= lfsr_nxt;
          end
        end
        S_FLUSH: begin
          // The final comparison lands on this same edge, so pass uses err_nxt.
          if (k == ({1'b0, n} + 9'd1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 8'd0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/test1_stim.md
# test1_stim

Self-checking stimulus/response harness for the `test1` timing sample netlist. It drives the 7-bit `a` input with an LFSR vector stream and samples the netlist's `b` output. It compares each `b` sample against a cycle-accurate golden model of the two-register-stage path and reports an error count and a pass flag. It sits opposite `test1` on the same `a`/`b`/`clk` interface, giving the STA sample set a closed, simulatable sequential loop.

## Interface
- `SEED`, 7'h01, LFSR seed loaded on every accepted `start`. A value of 0 is replaced by 7'h01.
- `clk`  input  1  single clock, shared with `test1`. All state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  run request; sampled only in IDLE or DONE.
- `count`  input  8  number of LFSR vectors N to drive; captured with `start`.
- `a_out`  output  7  registered drive to `test1.a`.
- `b_in`  input  1  `test1.b`, sampled at every rising edge.
- `busy`  output  1  run in progress.
- `done`  output  1  run finished. Level signal, held until the next accepted `start` or reset.
- `pass`  output  1  valid while `done`=1; 1 iff `err_count`==0.
- `err_count`  output  8  mismatch count; saturates at 255.

## Operation
- Golden functions: `c4(v) = ~(v[0]&v[1]) & ~v[2]` and `c5(v) = v[3] | v[4] | (v[5]&v[6])`.
- Expected `b` in drive cycle k: `c4(a_{k-2}) & c5(a_{k-1})`, where a_k is the value of `a_out` during cycle k.
- LFSR, 7-bit Fibonacci, period 127: `next = {s[5:0], s[6]^s[5]}`. Example sequence from 7'h01: 01,02,04,08,10,20,41,03.
- History registers: h1 holds a_{k-1} and h2 holds a_{k-2}. Both shift every cycle while `busy`=1.
- States and transitions:
  - IDLE → DRIVE when `start`=1 and `count`≠0. On this edge: capture N, load LFSR=SEED, clear `err_count`, set `done`=0 and `pass`=0.
  - IDLE/DONE with `start`=1 and `count`=0 → DONE directly, with `err_count`=0 and `pass`=1.
  - DRIVE: cycles k=0..N-1. `a_out` = a_0=SEED, then successive LFSR values. After cycle N-1 → FLUSH.
  - FLUSH: cycles k=N and N+1. `a_out`=0; these zeros are part of the model history. After cycle N+1 → DONE.
  - DONE: `busy`=0, `a_out`=0, `done`=1, `pass` = (`err_count`==0). `start` re-arms the block with the same rules as IDLE.
- Comparison runs at the edge ending cycle k, for 2≤k≤N+1 only, giving exactly N comparisons.
  - Cycles 0 and 1 are never compared, because the `test1` flops have no reset.
  - On mismatch, `err_count` increments, saturating at 255.
- `start` while `busy`=1 is ignored. `count` changes after capture have no effect.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `a_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, h1=h2=0, LFSR=SEED.
- Reset mid-run aborts the run with no completion indication.
- Start edge E0 (start=1) is followed by `a_out`=SEED and `busy`=1 in the next cycle (k=0).
- `busy` is high for exactly N+2 cycles.
- `done` rises at the edge ending cycle N+1, i.e. N+2 edges after E0. `busy` falls on the same edge.
- Final `err_count` is visible in the same cycle `done` rises.
- Simultaneous events:
  - A comparison in the last cycle and the DONE transition happen on the same edge; `pass` reflects that final comparison.
  - With `count`=0, `done`=1 appears 1 edge after E0.

## Test plan
- Reset then idle: `rst` pulse, then 5 cycles → `a_out`=0, `busy`=0, `done`=0, `err_count`=0.
- Closed loop with the real `test1`, SEED=7'h01, `count`=100 → `busy` high 102 cycles, `done`=1, `err_count`=0, `pass`=1. First `a_out` values are 01,02,04,08.
- `count`=1, `b_in` tied to 1, SEED=01 → one comparison (a_0=01, a_1=0, expected 0), `err_count`=1, `pass`=0, done 3 edges after start.
- `count`=255, `b_in`=~expected every cycle → `err_count` saturates at 255, `pass`=0.
- `count`=0 → `done`=1 one edge after start, `pass`=1, `busy` never asserted. `start` during a 10-vector run is ignored, and `done` occurs at edge 12.
- Reset asserted asynchronously at k=5 of a 20-vector run → all outputs drop to reset values before the next edge. A new `start` then gives a_0=SEED again.
